tm1638_cmd_arbiter: RTL and testbench
=====================================

Name: tm1638_cmd_arbiter

Overview:
- Shares the single TM1638 SPI command FIFO among NUM_REQ command sources: display refresh, LED update and brightness/config.
- Each source submits a burst of 18-bit command words. A burst is, for example, one address-set command followed by up to 16 data words.
- The arbiter grants one source at a time in round-robin order and holds the grant until that source's burst ends.
- It sits between the command generators and the SPI FIFO write port, upstream of the TM1638 driver.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 18, command word width, equal to the FIFO word width.
- MAX_BURST, 17, maximum number of words per grant. Reaching it forces a release.
- TIMEOUT_CYCLES, 256, number of consecutive idle cycles allowed in BURST before the grant is revoked.

Ports:
- i_Clk, in, 1, system clock. All logic is on posedge.
- i_Rst, in, 1, synchronous, active-low reset (0 = reset).
- i_Req_Valid, in, NUM_REQ, per-requester word valid.
- i_Req_Data, in, NUM_REQ*DATA_WIDTH, per-requester word. Requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_Req_Last, in, NUM_REQ, marks the final word of the burst. Qualified by valid.
- o_Req_Ready, out, NUM_REQ, per-requester accept. A handshake occurs when valid & ready.
- i_FIFO_Full, in, 1, FIFO almost-full: asserted when 1 or fewer entries are free.
- o_Data, out, DATA_WIDTH, registered word to the FIFO write port.
- o_Data_Valid, out, 1, FIFO write strobe. Exactly one cycle per accepted word.
- o_Grant, out, NUM_REQ, one-hot current owner. All zero when IDLE.
- o_Busy, out, 1, high in BURST.
- o_Diag_Timeout, out, 1, one-cycle pulse when a grant is revoked by timeout.
- o_Diag_Overrun, out, 1, one-cycle pulse when a grant is ended by MAX_BURST without Last.

Behaviour:
- Reset (i_Rst=0 at posedge):
  - state=IDLE.
  - o_Grant=0, o_Req_Ready=0, o_Data=0, o_Data_Valid=0, o_Busy=0, both diag pulses 0.
  - RR pointer=0, burst counter=0, idle counter=0.
  - Reset takes priority over every other event. A burst cut off mid-stream is abandoned; no word is emitted after reset.
- States: IDLE, BURST.
- IDLE:
  - If any i_Req_Valid is set, pick the first valid index searching from the RR pointer upward with wrap.
  - Register the winner into o_Grant, clear both counters, go to BURST.
  - o_Req_Ready=0 throughout IDLE, so the grant decision costs 1 cycle.
- BURST (owner g):
  - o_Req_Ready[g] = !i_FIFO_Full. This is combinational from state and i_FIFO_Full. All other ready bits are 0.
  - On a handshake: o_Data <= word[g] and o_Data_Valid <= 1 on the next edge. Latency from handshake to strobe is 1 cycle. The burst counter increments and the idle counter clears.
  - With no handshake: o_Data_Valid <= 0. o_Data holds its value.
- Release conditions, evaluated on the handshake word or on the idle count:
  - a) handshake with i_Req_Last[g]=1.
  - b) handshake where the burst counter reaches MAX_BURST with Last=0. Pulse o_Diag_Overrun.
  - c) idle counter reaches TIMEOUT_CYCLES. Pulse o_Diag_Timeout. No word is emitted.
  - Cycles stalled by i_FIFO_Full do not count as idle.
- On release: state goes to IDLE, o_Grant goes to 0, RR pointer <= (g+1) mod NUM_REQ. There is always at least one IDLE cycle between bursts.
- A word with Last=1 that is also word number MAX_BURST is a normal release (case a); no overrun pulse.
- Requests from non-owners during BURST are ignored, with no ready, until the next IDLE.
- Width rules:
  - Burst counter is $clog2(MAX_BURST+1) bits; idle counter is $clog2(TIMEOUT_CYCLES+1) bits.
  - Neither counter wraps: each is cleared on release.
- i_FIFO_Full asserted at the release cycle has no effect on the release itself.

Decomposition:
- Package tm1638_arb_types:
  - arb_state_t enum {IDLE, BURST}.
  - cmd_word_t, logic [17:0].
  - Constants MAX_BURST_DEFAULT=17 and TIMEOUT_DEFAULT=256.
- One sub-module: tm1638_rr_picker. It is purely combinational: inputs are the valid vector and the pointer, output is a one-hot winner. Find-first with wrap.

Test Plan:
- Single requester 0 sends 17 words, 0x00040..0x00050, Last on word 17 -> Grant=001 one cycle after first Valid. 17 Data_Valid strobes carry the values in order. Return to IDLE. Pointer=1.
- Requesters 0, 1, 2 all valid continuously, each sending 2-word bursts -> grant order 0, 1, 2, 0. Each burst is separated by exactly one IDLE cycle.
- i_FIFO_Full asserted for 5 cycles mid-burst -> Ready=0 for those 5 cycles, no strobes, no timeout. The remaining words follow unchanged.
- Requester 1 sends 17 words without Last -> o_Diag_Overrun pulses at the 17th handshake and the grant releases. An 18th Valid is not accepted until re-granted.
- Requester 2 sends 3 words, then drops Valid -> after 256 idle cycles o_Diag_Timeout pulses for 1 cycle, Grant=000, next pointer=0.
- Reset asserted (i_Rst=0) for 1 cycle after word 5 of a 10-word burst -> all outputs 0 on the next edge and no further strobes. Re-arbitration starts from requester 0.

Source files
------------

// File: rtl/tm1638_cmd_arbiter_pkg.sv
// Shared types and defaults for the TM1638 command-FIFO arbiter.
package tm1638_arb_types;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef logic [17:0] cmd_word_t;

    localparam int MAX_BURST_DEFAULT = 17;
    localparam int TIMEOUT_DEFAULT   = 256;

endpackage

// File: rtl/tm1638_cmd_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index at or above i_Ptr, with wrap.
module tm1638_rr_picker
    import tm1638_arb_types::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] i_Valid,
    input  logic [PW-1:0]      i_Ptr,
    output logic [NUM_REQ-1:0] o_Winner
);

    logic found;

    // Outer loop walks priority order starting at the pointer; inner loop maps it to an index.
    always_comb begin
        o_Winner = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (j == ((int'(i_Ptr) + i) % NUM_REQ)) && i_Valid[j]) begin
                    o_Winner[j] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tm1638_cmd_arbiter.sv
// Round-robin arbiter sharing the TM1638 SPI command FIFO among burst-oriented command sources.
module tm1638_cmd_arbiter
    import tm1638_arb_types::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = 18,
    parameter int MAX_BURST      = MAX_BURST_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic [NUM_REQ-1:0]            i_Req_Valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_Data,
    input  logic [NUM_REQ-1:0]            i_Req_Last,
    output logic [NUM_REQ-1:0]            o_Req_Ready,
    input  logic                          i_FIFO_Full,
    output logic [DATA_WIDTH-1:0]         o_Data,
    output logic                          o_Data_Valid,
    output logic [NUM_REQ-1:0]            o_Grant,
    output logic                          o_Busy,
    output logic                          o_Diag_Timeout,
    output logic                          o_Diag_Overrun
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [0:0]    S_IDLE      = IDLE;
    localparam logic [0:0]    S_BURST     = BURST;
    localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);
    localparam logic [IW-1:0] IDLE_LIMIT  = IW'(TIMEOUT_CYCLES);

    logic [0:0]            state;
    logic [NUM_REQ-1:0]    grant;
    logic [PW-1:0]         rr_ptr;
    logic [BW-1:0]         burst_cnt;
    logic [IW-1:0]         idle_cnt;

    logic [NUM_REQ-1:0]    winner;
    logic [PW-1:0]         owner_idx;
    logic [PW-1:0]         next_ptr;
    logic [DATA_WIDTH-1:0] owner_word;
    logic                  owner_last;
    logic                  handshake;
    logic [BW-1:0]         burst_cnt_inc;
    logic [IW-1:0]         idle_cnt_inc;

    tm1638_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_picker (
        .i_Valid  (i_Req_Valid),
        .i_Ptr    (rr_ptr),
        .o_Winner (winner)
    );

    always_comb begin
        owner_idx  = '0;
        owner_word = '0;
        owner_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                owner_idx  = PW'(k);
                owner_word = i_Req_Data[k*DATA_WIDTH +: DATA_WIDTH];
                owner_last = i_Req_Last[k];
            end
        end
    end

    // Handshake: a word moves when valid & ready are both high at a clock edge. Only the
    // owner sees ready, and only while the FIFO has room; valid never waits on ready.
    assign o_Req_Ready   = ((state == S_BURST) && !i_FIFO_Full) ? grant : '0;
    assign handshake     = |(i_Req_Valid & o_Req_Ready);
    assign next_ptr      = (owner_idx == PW'(NUM_REQ - 1)) ? '0 : owner_idx + PW'(1);
    assign burst_cnt_inc = burst_cnt + BW'(1);
    assign idle_cnt_inc  = idle_cnt + IW'(1);

    assign o_Grant = grant;
    assign o_Busy  = (state == S_BURST);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state          <= S_IDLE;
            grant          <= '0;
            rr_ptr         <= '0;
            burst_cnt      <= '0;
            idle_cnt       <= '0;
            o_Data         <= '0;
            o_Data_Valid   <= 1'b0;
            o_Diag_Timeout <= 1'b0;
            o_Diag_Overrun <= 1'b0;
        end else begin
            o_Data_Valid   <= 1'b0;
            o_Diag_Timeout <= 1'b0;
            o_Diag_Overrun <= 1'b0;
            if (state == S_IDLE) begin
                if (|i_Req_Valid) begin
                    grant     <= winner;
                    burst_cnt <= '0;
                    idle_cnt  <= '0;
                    state     <= S_BURST;
                end
            end else if (handshake) begin
                o_Data       <= owner_word;
                o_Data_Valid <= 1'b1;
                burst_cnt    <= burst_cnt_inc;
                idle_cnt     <= '0;
                // Last wins over the burst limit, so a final word at MAX_BURST is not an overrun.
                if (owner_last || (burst_cnt_inc == BURST_LIMIT)) begin
                    o_Diag_Overrun <= !owner_last;
                    state          <= S_IDLE;
                    grant          <= '0;
                    rr_ptr         <= next_ptr;
                    burst_cnt      <= '0;
                end
            end else if (!i_FIFO_Full) begin
                idle_cnt <= idle_cnt_inc;
                if (idle_cnt_inc == IDLE_LIMIT) begin
                    o_Diag_Timeout <= 1'b1;
                    state          <= S_IDLE;
                    grant          <= '0;
                    rr_ptr         <= next_ptr;
                    burst_cnt      <= '0;
                    idle_cnt       <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tm1638_cmd_arbiter.sv
// Bench for tm1638_cmd_arbiter: burst drivers, expected-word scoreboard and targeted timing checks.
module tb_tm1638_cmd_arbiter;
    import tm1638_arb_types::*;

    localparam int NR = 3;
    localparam int DW = 18;

    logic r_Clk = 1'b0;
    logic r_Rst = 1'b0;
    logic r_Full = 1'b0;
    logic req_v [NR] = '{default: 1'b0};
    logic req_l [NR] = '{default: 1'b0};
    logic [DW-1:0] req_w [NR] = '{default: '0};

    logic [NR-1:0]    w_Req_Valid, w_Req_Last, w_Req_Ready, w_Grant;
    logic [NR*DW-1:0] w_Req_Data;
    logic [DW-1:0]    w_Data;
    logic             w_Data_Valid, w_Busy, w_Diag_Timeout, w_Diag_Overrun;

    int total = 0;
    int bad = 0;
    int ovr_cnt = 0;
    int tmo_cnt = 0;
    int strobe_cnt = 0;
    int idle_run = 0;
    logic prev_busy = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [NR-1:0] grant_log[$];
    int gap_log[$];

    // clock / reset
    always #5 r_Clk = ~r_Clk;

    always_comb begin
        w_Req_Valid = '0;
        w_Req_Last  = '0;
        w_Req_Data  = '0;
        for (int k = 0; k < NR; k++) begin
            w_Req_Valid[k] = req_v[k];
            w_Req_Last[k]  = req_l[k];
            w_Req_Data[k*DW +: DW] = req_w[k];
        end
    end

    tm1638_cmd_arbiter #(
        .NUM_REQ (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST (17),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .i_Clk (r_Clk),
        .i_Rst (r_Rst),
        .i_Req_Valid (w_Req_Valid),
        .i_Req_Data (w_Req_Data),
        .i_Req_Last (w_Req_Last),
        .o_Req_Ready (w_Req_Ready),
        .i_FIFO_Full (r_Full),
        .o_Data (w_Data),
        .o_Data_Valid (w_Data_Valid),
        .o_Grant (w_Grant),
        .o_Busy (w_Busy),
        .o_Diag_Timeout (w_Diag_Timeout),
        .o_Diag_Overrun (w_Diag_Overrun)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge r_Clk);
        r_Rst = 1'b0;
        r_Full = 1'b0;
        for (int k = 0; k < NR; k++) begin
            req_v[k] = 1'b0;
            req_l[k] = 1'b0;
        end
        @(negedge r_Clk);
        @(negedge r_Clk);
        r_Rst = 1'b1;
        exp_q.delete();
        grant_log.delete();
        gap_log.delete();
        ovr_cnt = 0;
        tmo_cnt = 0;
        strobe_cnt = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge r_Clk);
    endtask

    // Drives n consecutive words base, base+1, ... from requester r, waiting for each handshake.
    task automatic send_burst(input int r, input int n, input logic [DW-1:0] base, input bit use_last);
        int budget;
        bit ok;
        for (int w = 0; w < n; w++) begin
            @(negedge r_Clk);
            req_v[r] = 1'b1;
            req_w[r] = base + DW'(w);
            req_l[r] = use_last && (w == n - 1);
            ok = 1'b0;
            budget = 0;
            while (!ok && budget < 2000) begin
                #1;
                if (w_Req_Ready[r] === 1'b1) ok = 1'b1;
                else begin
                    @(negedge r_Clk);
                    budget++;
                end
            end
            if (!ok) begin
                check("drv_budget", budget, 0);
                req_v[r] = 1'b0;
                req_l[r] = 1'b0;
                return;
            end
            @(posedge r_Clk);
        end
        @(negedge r_Clk);
        req_v[r] = 1'b0;
        req_l[r] = 1'b0;
    endtask

    // scoreboard / monitor
    always begin
        @(negedge r_Clk);
        #2;
        if (w_Data_Valid === 1'b1) begin
            strobe_cnt++;
            if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
            else check("sb_data", w_Data, exp_q.pop_front());
        end
        if (w_Diag_Overrun === 1'b1) ovr_cnt++;
        if (w_Diag_Timeout === 1'b1) tmo_cnt++;
        if (w_Busy === 1'b1 && !prev_busy) begin
            grant_log.push_back(w_Grant);
            gap_log.push_back(idle_run);
        end
        if (w_Busy === 1'b1) idle_run = 0;
        else idle_run++;
        prev_busy = (w_Busy === 1'b1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: sim time exceeded, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // reset state and single-requester 17-word burst
        do_reset();
        #2;
        check("rst_grant", w_Grant, 0);
        check("rst_ready", w_Req_Ready, 0);
        check("rst_data", w_Data, 0);
        check("rst_dv", w_Data_Valid, 0);
        check("rst_busy", w_Busy, 0);
        check("rst_tmo", w_Diag_Timeout, 0);
        check("rst_ovr", w_Diag_Overrun, 0);
        for (int i = 0; i < 17; i++) exp_q.push_back(DW'(32'h40 + i));
        fork
            send_burst(0, 17, 18'h00040, 1'b1);
            begin
                @(negedge r_Clk);
                #2;
                check("t1_grant_pre", w_Grant, 0);
                @(negedge r_Clk);
                #2;
                check("t1_grant", w_Grant, 3'b001);
            end
        join
        idle_cycles(2);
        #2;
        check("t1_grant_end", w_Grant, 0);
        check("t1_busy_end", w_Busy, 0);
        check("t1_strobes", strobe_cnt, 17);
        check("t1_sb_empty", exp_q.size(), 0);
        check("t1_ovr", ovr_cnt, 0);
        // pointer now 1: requester 1 beats requester 0
        exp_q.push_back(18'h00070);
        exp_q.push_back(18'h00060);
        fork
            send_burst(0, 1, 18'h00060, 1'b1);
            send_burst(1, 1, 18'h00070, 1'b1);
        join
        idle_cycles(3);
        check("t1_ptr_sb", exp_q.size(), 0);
        if (grant_log.size() >= 2) check("t1_ptr_grant", grant_log[1], 3'b010);
        else check("t1_ptr_glog", grant_log.size(), 2);

        // three contending requesters, 2-word bursts
        do_reset();
        for (int i = 0; i < 2; i++) exp_q.push_back(DW'(32'h100 + i));
        for (int i = 0; i < 2; i++) exp_q.push_back(DW'(32'h200 + i));
        for (int i = 0; i < 2; i++) exp_q.push_back(DW'(32'h300 + i));
        for (int i = 0; i < 2; i++) exp_q.push_back(DW'(32'h400 + i));
        fork
            begin
                send_burst(0, 2, 18'h00100, 1'b1);
                send_burst(0, 2, 18'h00400, 1'b1);
            end
            send_burst(1, 2, 18'h00200, 1'b1);
            send_burst(2, 2, 18'h00300, 1'b1);
        join
        idle_cycles(3);
        check("t2_sb_empty", exp_q.size(), 0);
        check("t2_glog_size", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("t2_g0", grant_log[0], 3'b001);
            check("t2_g1", grant_log[1], 3'b010);
            check("t2_g2", grant_log[2], 3'b100);
            check("t2_g3", grant_log[3], 3'b001);
            for (int i = 1; i < 4; i++) check("t2_gap", gap_log[i], 1);
        end

        // FIFO full stall mid-burst
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(DW'(32'h900 + i));
        fork
            send_burst(0, 8, 18'h00900, 1'b1);
            begin
                repeat (4) @(negedge r_Clk);
                r_Full = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge r_Clk);
                    #2;
                    check("t3_ready_stall", w_Req_Ready, 0);
                    if (i > 0) check("t3_no_strobe", w_Data_Valid, 0);
                end
                @(negedge r_Clk);
                r_Full = 1'b0;
                #2;
                check("t3_no_strobe_end", w_Data_Valid, 0);
            end
        join
        idle_cycles(3);
        check("t3_sb_empty", exp_q.size(), 0);
        check("t3_tmo", tmo_cnt, 0);

        // overrun: 17 words without Last, 18th waits for a new grant
        do_reset();
        for (int i = 0; i < 18; i++) exp_q.push_back(DW'(32'h500 + i));
        fork
            send_burst(1, 18, 18'h00500, 1'b1);
            begin
                n = 0;
                while (w_Diag_Overrun !== 1'b1 && n < 300) begin
                    @(negedge r_Clk);
                    #2;
                    n++;
                end
                check("t4_ovr_seen", w_Diag_Overrun, 1);
                check("t4_ovr_word", w_Data, 18'h00510);
                check("t4_ovr_strobe", w_Data_Valid, 1);
                check("t4_ovr_grant", w_Grant, 0);
                check("t4_ovr_ready", w_Req_Ready, 0);
                @(negedge r_Clk);
                #2;
                check("t4_ovr_pulse1", w_Diag_Overrun, 0);
            end
        join
        idle_cycles(3);
        check("t4_sb_empty", exp_q.size(), 0);
        check("t4_ovr_cnt", ovr_cnt, 1);
        if (grant_log.size() == 2) begin
            check("t4_regrant", grant_log[1], 3'b010);
            check("t4_gap", gap_log[1], 1);
        end else check("t4_glog_size", grant_log.size(), 2);

        // timeout after requester 2 goes quiet
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(DW'(32'h600 + i));
        send_burst(2, 3, 18'h00600, 1'b0);
        #2;
        n = 0;
        while (w_Diag_Timeout !== 1'b1 && n < 400) begin
            @(negedge r_Clk);
            #2;
            n++;
        end
        check("t5_idle_cycles", n, 256);
        check("t5_tmo_seen", w_Diag_Timeout, 1);
        check("t5_grant", w_Grant, 0);
        @(negedge r_Clk);
        #2;
        check("t5_tmo_pulse1", w_Diag_Timeout, 0);
        check("t5_sb_empty", exp_q.size(), 0);
        exp_q.push_back(18'h00700);
        exp_q.push_back(18'h00710);
        fork
            send_burst(0, 1, 18'h00700, 1'b1);
            send_burst(1, 1, 18'h00710, 1'b1);
        join
        idle_cycles(3);
        check("t5_ptr_sb", exp_q.size(), 0);
        check("t5_tmo_cnt", tmo_cnt, 1);
        check("t5_ovr_cnt", ovr_cnt, 0);

        // reset in the middle of a 10-word burst
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(DW'(32'h800 + i));
        send_burst(0, 5, 18'h00800, 1'b0);
        r_Rst = 1'b0;
        req_v[0] = 1'b1;
        req_w[0] = 18'h00805;
        @(negedge r_Clk);
        #2;
        check("t6_grant", w_Grant, 0);
        check("t6_ready", w_Req_Ready, 0);
        check("t6_data", w_Data, 0);
        check("t6_dv", w_Data_Valid, 0);
        check("t6_busy", w_Busy, 0);
        check("t6_diag", {w_Diag_Timeout, w_Diag_Overrun}, 0);
        req_v[0] = 1'b0;
        r_Rst = 1'b1;
        idle_cycles(2);
        check("t6_no_strobe", exp_q.size(), 0);
        exp_q.push_back(18'h00805);
        exp_q.push_back(18'h008A0);
        fork
            send_burst(0, 1, 18'h00805, 1'b1);
            send_burst(1, 1, 18'h008A0, 1'b1);
        join
        idle_cycles(3);
        check("t6_rearb_sb", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
